icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Instruction cache between the pipelined CPU's fetch port (readM1/address1/data1) and the instruction memory.
- Direct-mapped, read-only, with 16-bit word addressing.
- A hit returns the instruction in the same cycle. A miss stalls fetch while the cache fetches the whole line word by word over a request/acknowledge memory handshake.
- The pipeline uses `ready` as its IF stall condition, gating PC_WriteEn and IFID_WriteEn.

Parameters:
- WORD_SIZE, 16, data and address width.
- OFFSET_BITS, 2, log2 of words per line (4 words per line).
- INDEX_BITS, 2, log2 of line count (4 lines).
- TAG_BITS, WORD_SIZE-OFFSET_BITS-INDEX_BITS = 12, tag width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  synchronous reset, active-high: 1 resets on the next rising edge of clk.
- cpu_read  in  1  fetch request (CPU readM1).
- cpu_addr  in  16  fetch word address (CPU address1).
- cpu_data  out  16  instruction word, valid when ready=1.
- ready  out  1  hit this cycle; 0 means stall IF.
- inv_all  in  1  invalidate every line.
- mem_req  out  1  memory word-read request.
- mem_addr  out  16  memory word address.
- mem_ack  in  1  one-cycle pulse: mem_data is valid this cycle.
- mem_data  in  16  memory read data.
- hit_count  out  16  hits counted since reset.
- miss_count  out  16  misses counted since reset.

Behaviour:
- Address split: tag = addr[15:4], index = addr[3:2], offset = addr[1:0].
- Storage per line: valid bit, 12-bit tag, 4x16 data words.
- Reset (reset_n=1 at the edge):
  - all valid bits 0, state COMPARE, fill counter 0, counters 0.
  - Resulting outputs: mem_req=0, mem_addr=0, ready=0, cpu_data=0.
  - Reset mid-FILL abandons the fill; no partial line is installed.
- COMPARE state:
  - hit = cpu_read & valid[index] & tag match.
  - ready=hit and cpu_data=line[index][offset] combinationally, with zero added latency.
  - cpu_read=0 gives ready=0, cpu_data=0, no counting.
  - On a hit edge, hit_count increments.
  - On a miss (cpu_read & ~hit): latch miss_tag/miss_index, fill counter=0, miss_count increments, go to FILL.
- FILL state:
  - mem_req=1, mem_addr={miss_tag, miss_index, cnt}, ready=0.
  - On mem_ack, write mem_data into the fill buffer word cnt and increment cnt.
  - When mem_ack arrives with cnt=3: write the buffer, valid=1 and miss_tag into line miss_index, then go to COMPARE.
  - mem_req stays high from the first FILL cycle until the edge that takes the last ack; the memory may hold ack low for any number of cycles.
- Return from FILL: the first COMPARE cycle re-evaluates the current cpu_addr. The same address hits, so the miss penalty equals the time spent in FILL plus 1 cycle.
- Stall requirement: the CPU holds cpu_addr stable while ready=0. The cache fills from the latched address regardless.
- inv_all:
  - In COMPARE: clears every valid bit at the edge; ready is forced 0 in that same cycle.
  - In FILL: clears the valid bits, but the line being filled is still installed valid on completion.
- Counters: 16-bit, wrap 0xFFFF->0x0000.
- A hit is counted once per cycle with ready=1. Repeated hits while the pipeline stalls for other reasons are counted each cycle.
- mem_ack while in COMPARE is ignored.

Decomposition:
- Shared package:
  - WORD_SIZE and the OFFSET/INDEX/TAG widths.
  - state encoding: COMPARE=1'b0, FILL=1'b1.
  - address-field extraction helpers.
- One sub-module, icache_line_store: valid/tag/data arrays with
  - a combinational read port (index, offset),
  - a line-write port (index, tag, 64-bit line),
  - a synchronous valid-clear.
- The FSM, fill buffer and counters stay in icache_direct.

Test Plan:
- Cold miss, then sequential fetches:
  - Stimulus: reset, then cpu_read=1, cpu_addr=0x0000; memory returns word=addr+0x1000 with ack 2 cycles after req.
  - Required: mem_addr steps 0x0000..0x0003.
  - Required: ready=1 with cpu_data=0x1000 on the cycle after the 4th ack.
  - Required: addrs 0x0001..0x0003 then hit in consecutive cycles.
  - Required: miss_count=1, hit_count=4.
- Conflict miss:
  - Stimulus: after line 0 holds tag 0x000, fetch 0x0010 (index 0, tag 0x001).
  - Required: miss; refill from 0x0010..0x0013.
  - Required: re-fetching 0x0000 misses again; miss_count=3.
- Variable ack latency:
  - Stimulus: ack delays 0, 5, 1, 3 cycles.
  - Required: mem_req stays 1 throughout and the words land in the correct offsets.
  - Required: mem_ack pulses injected in COMPARE change no state.
- inv_all:
  - Stimulus: warm lines 0..3, pulse inv_all.
  - Required: next fetch of 0x0005 misses.
  - Stimulus: pulse inv_all during a fill of 0x0020.
  - Required: 0x0020 hits after the fill completes.
- Reset mid-FILL:
  - Stimulus: assert reset_n=1 after the 2nd ack.
  - Required: mem_req=0 the next cycle; counters 0; a fetch of the same address misses and fetches all 4 words.
- Counter wrap:
  - Stimulus: preload via 65535 hits, then one more hit.
  - Required: hit_count=0x0000, miss_count unchanged.

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared widths, FSM encoding and address-field helpers for the direct-mapped I-cache.
package icache_direct_pkg;

  localparam int unsigned WORD_SIZE      = 16;
  localparam int unsigned OFFSET_BITS    = 2;
  localparam int unsigned INDEX_BITS     = 2;
  localparam int unsigned TAG_BITS       = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
  localparam int unsigned WORDS_PER_LINE = 1 << OFFSET_BITS;
  localparam int unsigned NUM_LINES      = 1 << INDEX_BITS;
  localparam int unsigned LINE_BITS      = WORD_SIZE * WORDS_PER_LINE;
  localparam int unsigned CNT_BITS       = 16;

  // Controller states
  localparam logic [0:0] ST_COMPARE = 1'b0;
  localparam logic [0:0] ST_FILL    = 1'b1;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [WORD_SIZE-1:0] addr);
    return addr[WORD_SIZE-1 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [WORD_SIZE-1:0] addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [WORD_SIZE-1:0] addr);
    return addr[OFFSET_BITS-1:0];
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational word read, whole-line write, bulk valid clear.
module icache_line_store
  import icache_direct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr_valid,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid_c,
  output logic [TAG_BITS-1:0]    rd_tag_c,
  output logic [WORD_SIZE-1:0]   rd_word_c,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]    wr_tag,
  input  logic [LINE_BITS-1:0]   wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

  // Valid bits: a line install wins over a same-cycle bulk clear.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      valid_q <= '0;
    end else begin
      if (clr_valid) valid_q <= '0;
      if (wr_en)     valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays are written only on a completed line fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
        data_q[wr_index][OFFSET_BITS'(w)] <= wr_line[w*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign rd_valid_c = valid_q[rd_index];
  assign rd_tag_c   = tag_q[rd_index];
  assign rd_word_c  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with same-cycle hits and word-by-word line refill.
module icache_direct
  import icache_direct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_read,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  output logic [WORD_SIZE-1:0] cpu_data,
  output logic                 ready,
  input  logic                 inv_all,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [CNT_BITS-1:0]  hit_count,
  output logic [CNT_BITS-1:0]  miss_count
);

  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS_PER_LINE - 1);

  logic [0:0]             state_q, state_d;
  logic [OFFSET_BITS-1:0] fill_cnt_q;
  logic [TAG_BITS-1:0]    miss_tag_q;
  logic [INDEX_BITS-1:0]  miss_index_q;
  logic [WORD_SIZE-1:0]   fill_buf_q [WORDS_PER_LINE-1];
  logic [CNT_BITS-1:0]    hit_count_q, miss_count_q;
  logic                   mem_req_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;

  logic                   rd_valid_c;
  logic [TAG_BITS-1:0]    rd_tag_c;
  logic [WORD_SIZE-1:0]   rd_word_c;
  logic                   lookup_hit_c, miss_c, fill_ack_c, fill_done_c;
  logic [LINE_BITS-1:0]   wr_line_c;

  icache_line_store u_store (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_valid  (inv_all),
    .rd_index   (addr_index(cpu_addr)),
    .rd_offset  (addr_offset(cpu_addr)),
    .rd_valid_c (rd_valid_c),
    .rd_tag_c   (rd_tag_c),
    .rd_word_c  (rd_word_c),
    .wr_en      (fill_done_c),
    .wr_index   (miss_index_q),
    .wr_tag     (miss_tag_q),
    .wr_line    (wr_line_c)
  );

  // Last word bypasses the buffer so the line installs on the edge of the final ack.
  assign wr_line_c = {mem_data, fill_buf_q[2], fill_buf_q[1], fill_buf_q[0]};

  // Lookup, miss detection and next-state selection.
  always_comb begin
    state_d      = state_q;
    lookup_hit_c = 1'b0;
    miss_c       = 1'b0;
    fill_ack_c   = 1'b0;
    fill_done_c  = 1'b0;
    case (state_q)
      ST_COMPARE: begin
        lookup_hit_c = cpu_read & rd_valid_c & (rd_tag_c == addr_tag(cpu_addr)) & ~inv_all;
        miss_c       = cpu_read & ~lookup_hit_c;
        if (miss_c) state_d = ST_FILL;
      end
      ST_FILL: begin
        fill_ack_c  = mem_ack;
        fill_done_c = mem_ack & (fill_cnt_q == LAST_WORD);
        if (fill_done_c) state_d = ST_COMPARE;
      end
      default: state_d = ST_COMPARE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_n) state_q <= ST_COMPARE;
    else         state_q <= state_d;
  end

  // Miss capture, fill sequencing, memory request and event counters.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      fill_cnt_q    <= '0;
      miss_tag_q    <= '0;
      miss_index_q  <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      for (int unsigned w = 0; w < WORDS_PER_LINE - 1; w++) fill_buf_q[w] <= '0;
    end else begin
      if (lookup_hit_c) hit_count_q <= hit_count_q + 16'd1;
      if (miss_c) begin
        miss_tag_q   <= addr_tag(cpu_addr);
        miss_index_q <= addr_index(cpu_addr);
        fill_cnt_q   <= '0;
        miss_count_q <= miss_count_q + 16'd1;
        mem_req_q    <= 1'b1;
        mem_addr_q   <= {addr_tag(cpu_addr), addr_index(cpu_addr), {OFFSET_BITS{1'b0}}};
      end
      if (fill_ack_c) begin
        fill_cnt_q <= fill_cnt_q + 2'd1;
        case (fill_cnt_q)
          2'd0:    fill_buf_q[0] <= mem_data;
          2'd1:    fill_buf_q[1] <= mem_data;
          2'd2:    fill_buf_q[2] <= mem_data;
          default: ;
        endcase
        if (fill_done_c) begin
          mem_req_q  <= 1'b0;
          mem_addr_q <= '0;
        end else begin
          mem_addr_q <= {miss_tag_q, miss_index_q, fill_cnt_q + 2'd1};
        end
      end
    end
  end

  assign ready      = lookup_hit_c;
  assign cpu_data   = lookup_hit_c ? rd_word_c : '0;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed plus randomized bench for icache_direct against a line-level cache model.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        ready;
  logic        inv_all;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  icache_direct dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_read   (cpu_read),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .ready      (ready),
    .inv_all    (inv_all),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: per-line valid/tag/words plus event counters.
  logic        m_valid [4];
  logic [11:0] m_tag   [4];
  logic [15:0] m_data  [4][4];
  logic [15:0] m_hits, m_miss;
  int          dly [4];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%04h expected=0x%04h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_hits = 16'd0;
    m_miss = 16'd0;
  endtask

  task automatic check_counters();
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
  endtask

  task automatic do_reset();
    cpu_read = 1'b0;
    inv_all  = 1'b0;
    mem_ack  = 1'b0;
    reset_n  = 1'b1;
    tick();
    tick();
    reset_n  = 1'b0;
    model_reset();
  endtask

  task automatic invalidate();
    cpu_read = 1'b0;
    inv_all  = 1'b1;
    #1;
    chk("inv_ready", ready, 1'b0);
    tick();
    inv_all = 1'b0;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  task automatic idle_cycle();
    cpu_read = 1'b0;
    cpu_addr = 16'($urandom);
    #1;
    chk("idle_ready", ready, 1'b0);
    chk("idle_data", cpu_data, 16'h0000);
    tick();
  endtask

  // Fetch one address; on a miss act as memory with latencies dly[], optionally
  // pulsing inv_all alongside ack inv_word, or resetting after abort_after acks.
  task automatic fetch(input logic [15:0] a, input int abort_after, input int inv_word);
    logic [1:0]  idx;
    logic [1:0]  off;
    logic        exp_hit;
    logic [15:0] wa;
    idx = a[3:2];
    off = a[1:0];
    cpu_read = 1'b1;
    cpu_addr = a;
    #1;
    exp_hit = m_valid[idx] && (m_tag[idx] == a[15:4]);
    chk("lookup_ready", ready, exp_hit);
    if (exp_hit) begin
      chk("hit_data", cpu_data, m_data[idx][off]);
      m_hits++;
      tick();
      return;
    end
    m_miss++;
    tick();
    for (int w = 0; w < 4; w++) begin
      wa = {a[15:2], 2'(w)};
      if (w == abort_after) begin
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        model_reset();
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_mem_addr", mem_addr, 16'h0000);
        check_counters();
        return;
      end
      for (int c = 0; c < dly[w]; c++) begin
        chk("wait_mem_req", mem_req, 1'b1);
        chk("wait_mem_addr", mem_addr, wa);
        chk("wait_ready", ready, 1'b0);
        tick();
      end
      mem_ack  = 1'b1;
      mem_data = mem_word(wa);
      inv_all  = (w == inv_word);
      #1;
      chk("ack_mem_req", mem_req, 1'b1);
      chk("ack_mem_addr", mem_addr, wa);
      chk("ack_ready", ready, 1'b0);
      tick();
      mem_ack  = 1'b0;
      mem_data = 16'($urandom);
      if (inv_all) for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      inv_all  = 1'b0;
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = a[15:4];
    for (int w = 0; w < 4; w++) m_data[idx][w] = mem_word({a[15:2], 2'(w)});
    #1;
    chk("fill_done_mem_req", mem_req, 1'b0);
    chk("return_ready", ready, 1'b1);
    chk("return_data", cpu_data, m_data[idx][off]);
    m_hits++;
    tick();
  endtask

  initial begin
    reset_n  = 1'b1;
    cpu_read = 1'b0;
    cpu_addr = 16'h0000;
    inv_all  = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    for (int i = 0; i < 4; i++) dly[i] = 2;
    do_reset();

    // Reset state
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ready", ready, 1'b0);
    chk("rst_cpu_data", cpu_data, 16'h0000);
    check_counters();

    // Cold miss then sequential hits
    fetch(16'h0000, -1, -1);
    fetch(16'h0001, -1, -1);
    fetch(16'h0002, -1, -1);
    fetch(16'h0003, -1, -1);
    chk("cold_miss_count", miss_count, 16'd1);
    chk("cold_hit_count", hit_count, 16'd4);

    // Conflict miss in index 0
    fetch(16'h0010, -1, -1);
    fetch(16'h0000, -1, -1);
    chk("conflict_miss_count", miss_count, 16'd3);
    check_counters();

    // Variable ack latency
    dly[0] = 0; dly[1] = 5; dly[2] = 1; dly[3] = 3;
    fetch(16'h0024, -1, -1);
    fetch(16'h0027, -1, -1);

    // Acks while in COMPARE are ignored
    cpu_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack  = 1'b1;
      mem_data = 16'($urandom);
      #1;
      chk("stray_ack_mem_req", mem_req, 1'b0);
      tick();
    end
    mem_ack = 1'b0;
    check_counters();
    fetch(16'h0025, -1, -1);
    fetch(16'h0001, -1, -1);

    // inv_all in COMPARE
    for (int i = 0; i < 4; i++) dly[i] = 1;
    fetch(16'h0000, -1, -1);
    fetch(16'h0004, -1, -1);
    fetch(16'h0008, -1, -1);
    fetch(16'h000C, -1, -1);
    invalidate();
    fetch(16'h0005, -1, -1);
    check_counters();

    // inv_all during a fill keeps the line being filled
    fetch(16'h0020, -1, 1);
    fetch(16'h0020, -1, -1);
    fetch(16'h0006, -1, -1);
    fetch(16'h0030, -1, 3);
    fetch(16'h0031, -1, -1);
    check_counters();

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < 4; i++) dly[i] = int'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0:       invalidate();
        1:       idle_cycle();
        default: fetch(16'($urandom_range(0, 3) * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3)),
                       -1, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
      endcase
    end
    check_counters();

    // Reset mid-fill, then the same address refetches the whole line
    invalidate();
    for (int i = 0; i < 4; i++) dly[i] = 1;
    fetch(16'h0032, 2, -1);
    chk("post_abort_ready", ready, 1'b0);
    fetch(16'h0032, -1, -1);
    chk("refill_miss_count", miss_count, 16'd1);
    check_counters();

    // Hit counter wrap
    do_reset();
    fetch(16'h0000, -1, -1);
    while (m_hits != 16'hFFFF) begin
      tick();
      m_hits++;
    end
    chk("hit_count_ffff", hit_count, 16'hFFFF);
    tick();
    m_hits++;
    chk("hit_count_wrap", hit_count, 16'h0000);
    chk("miss_count_after_wrap", miss_count, 16'd1);
    cpu_read = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
